// File: rtl/apb_fifo_slave_pkg.sv
// Shared constants for the APB FIFO slave: register offsets, CTRL bit indices, FSM states.
package apb_fifo_slave_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 4;

    localparam logic [ADDR_W-1:0] CTRL_OFS   = 12'h000;
    localparam logic [ADDR_W-1:0] STATUS_OFS = 12'h004;
    localparam logic [ADDR_W-1:0] TXDATA_OFS = 12'h008;
    localparam logic [ADDR_W-1:0] RXDATA_OFS = 12'h00C;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_FLUSH_BIT  = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/apb_sync_fifo.sv
// Single-clock word FIFO with flush; head word is presented combinationally on rdata.
module apb_sync_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer fronting a word FIFO with programmable wait states.
// Optional APB_SLVERR_EN adds a PSLVERR output for unmapped or illegal accesses.
module apb_fifo_slave
    import apb_fifo_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
`ifdef APB_SLVERR_EN
    output logic        PSLVERR,
`endif
    output logic        irq
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                en_q;
    logic                irq_en_q;

    logic                done;
    logic                sel_ctrl, sel_status, sel_tx, sel_rx;
    logic                fifo_push, fifo_pop, fifo_flush, ctrl_wr;
    logic [DATA_W-1:0]   fifo_head;
    logic                fifo_empty, fifo_full;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W-1:0]   rd_value;
    logic                unused_paddr;

    assign unused_paddr = ^PADDR[31:ADDR_W];

    // The transfer completes (and its side effect fires) in the last ACCESS cycle.
    assign done   = (state_q == ST_ACCESS) && PSEL && (wait_q == '0);
    assign PREADY = done;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR[ADDR_W-1:0];
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    wait_d  = WAIT_W'(WAIT_CYCLES);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A dropped PSEL abandons the transfer without touching the FIFO or CTRL.
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel_ctrl   = (addr_q == CTRL_OFS);
    assign sel_status = (addr_q == STATUS_OFS);
    assign sel_tx     = (addr_q == TXDATA_OFS);
    assign sel_rx     = (addr_q == RXDATA_OFS);

    assign ctrl_wr    = done & write_q & sel_ctrl;
    assign fifo_flush = ctrl_wr & wdata_q[CTRL_FLUSH_BIT];
    assign fifo_push  = done & write_q & sel_tx & en_q & ~fifo_full;
    assign fifo_pop   = done & ~write_q & sel_rx & ~fifo_empty;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
        end else if (ctrl_wr) begin
            en_q     <= wdata_q[CTRL_EN_BIT];
            irq_en_q <= wdata_q[CTRL_IRQ_EN_BIT];
        end
    end

    apb_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (wdata_q),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        rd_value = '0;
        case (addr_q)
            CTRL_OFS: begin
                rd_value[CTRL_EN_BIT]     = en_q;
                rd_value[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            STATUS_OFS: begin
                rd_value[0]    = fifo_empty;
                rd_value[1]    = fifo_full;
                rd_value[15:8] = 8'(fifo_count);
            end
            RXDATA_OFS: rd_value = fifo_empty ? '0 : fifo_head;
            default:    rd_value = '0;
        endcase
    end

    assign PRDATA = (done && !write_q) ? rd_value : '0;
    assign irq    = irq_en_q & ~fifo_empty;

`ifdef APB_SLVERR_EN
    logic access_err;

    assign access_err = ~(sel_ctrl | sel_status | sel_tx | sel_rx)
                      | (write_q & (sel_status | sel_rx))
                      | (write_q & sel_tx & (~en_q | fifo_full))
                      | (~write_q & sel_rx & fifo_empty);
    assign PSLVERR    = done & access_err;
`endif

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Randomized bench for apb_fifo_slave: two instances (0 and 3 wait states) against a queue model.
`timescale 1ns/1ps
module tb_apb_fifo_slave;

    localparam int unsigned DEPTH   = 8;
    localparam int          MAX_LAT = 20;

    logic        PCLK;
    logic        PRESET;
    logic [1:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        irq    [2];
    logic        pslverr [2];

    int          checks;
    int          errors;
    logic [31:0] last_rd;

    // Reference model state per instance
    logic [31:0] mq [2][$];
    logic        men  [2];
    logic        mirq [2];

    apb_fifo_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (psel[0]),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (prdata[0]),
        .PREADY  (pready[0]),
`ifdef APB_SLVERR_EN
        .PSLVERR (pslverr[0]),
`endif
        .irq     (irq[0])
    );

    apb_fifo_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (psel[1]),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (prdata[1]),
        .PREADY  (pready[1]),
`ifdef APB_SLVERR_EN
        .PSLVERR (pslverr[1]),
`endif
        .irq     (irq[1])
    );

`ifndef APB_SLVERR_EN
    assign pslverr[0] = 1'b0;
    assign pslverr[1] = 1'b0;
`endif

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            men[d]  = 1'b0;
            mirq[d] = 1'b0;
        end
    endtask

    // Register-map semantics evaluated on the model; returns expected read data and error flag.
    task automatic model_access(input int d, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
        int sz;
        rd  = 32'h0;
        err = 1'b0;
        sz  = mq[d].size();
        case (addr[11:0])
            12'h000: begin
                if (wr) begin
                    men[d]  = wdata[0];
                    mirq[d] = wdata[2];
                    if (wdata[1]) mq[d].delete();
                end else begin
                    rd = {29'h0, mirq[d], 1'b0, men[d]};
                end
            end
            12'h004: begin
                if (wr) err = 1'b1;
                else rd = {16'h0, 8'(sz), 6'h0, (sz == int'(DEPTH)), (sz == 0)};
            end
            12'h008: begin
                if (wr) begin
                    if (!men[d] || sz == int'(DEPTH)) err = 1'b1;
                    else mq[d].push_back(wdata);
                end
            end
            12'h00C: begin
                if (wr) err = 1'b1;
                else if (sz == 0) err = 1'b1;
                else rd = mq[d].pop_front();
            end
            default: err = 1'b1;
        endcase
    endtask

    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        model_access(d, wr, addr, wdata, exp_rd, exp_err);
        @(negedge PCLK);
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        lat     = 1;
        while (!pready[d] && lat <= MAX_LAT) begin
            check("prdata_wait", prdata[d], 32'h0);
            @(negedge PCLK);
            lat++;
        end
        check("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        check("prdata", prdata[d], exp_rd);
`ifdef APB_SLVERR_EN
        check("pslverr", 32'(pslverr[d]), 32'(exp_err));
`endif
        last_rd = prdata[d];
        @(negedge PCLK);
        psel[d] = 1'b0;
        PENABLE = 1'b0;
        check("irq", 32'(irq[d]), 32'(mirq[d] && mq[d].size() != 0));
    endtask

    initial begin
        int          d;
        int          kind;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;

        checks  = 0;
        errors  = 0;
        last_rd = 32'h0;
        psel    = 2'b00;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h0;
        PWDATA  = 32'h0;
        PRESET  = 1'b0;
        model_reset();

        repeat (3) @(negedge PCLK);
        for (int i = 0; i < 2; i++) begin
            check("rst_pready", 32'(pready[i]), 32'h0);
            check("rst_prdata", prdata[i], 32'h0);
            check("rst_irq", 32'(irq[i]), 32'h0);
        end
        PRESET = 1'b1;

        apb_xfer(0, 1'b0, 32'h4, 32'h0);
        check("status_after_reset", last_rd, 32'h0000_0001);

        // Basic push/pop with interrupt enabled
        apb_xfer(0, 1'b1, 32'h0, 32'h5);
        apb_xfer(0, 1'b1, 32'h8, 32'hA5A5_0001);
        apb_xfer(0, 1'b1, 32'h8, 32'hA5A5_0002);
        apb_xfer(0, 1'b0, 32'h4, 32'h0);
        check("status_two", last_rd, 32'h0000_0200);
        check("irq_two", 32'(irq[0]), 32'h1);
        apb_xfer(0, 1'b0, 32'hC, 32'h0);
        check("pop_first", last_rd, 32'hA5A5_0001);
        apb_xfer(0, 1'b0, 32'hC, 32'h0);
        check("pop_second", last_rd, 32'hA5A5_0002);
        apb_xfer(0, 1'b0, 32'h4, 32'h0);
        check("status_drained", last_rd, 32'h0000_0001);

        // Fill beyond capacity
        for (int i = 0; i < 9; i++) apb_xfer(0, 1'b1, 32'h8, 32'h10 + 32'(i));
        apb_xfer(0, 1'b0, 32'h4, 32'h0);
        check("status_full", last_rd, 32'h0000_0802);
        apb_xfer(0, 1'b0, 32'hC, 32'h0);
        check("pop_after_full", last_rd, 32'h10);

        // Flush with three words queued, then pop on empty
        apb_xfer(0, 1'b1, 32'h0, 32'h3);
        for (int i = 0; i < 3; i++) apb_xfer(0, 1'b1, 32'h8, 32'hBEEF_0000 + 32'(i));
        apb_xfer(0, 1'b1, 32'h0, 32'h3);
        apb_xfer(0, 1'b0, 32'h4, 32'h0);
        check("status_flushed", last_rd, 32'h0000_0001);
        apb_xfer(0, 1'b0, 32'h0, 32'h0);
        check("ctrl_readback", last_rd, 32'h0000_0001);
        apb_xfer(0, 1'b0, 32'hC, 32'h0);
        check("pop_empty", last_rd, 32'h0);
        apb_xfer(0, 1'b1, 32'h8, 32'h77);
        apb_xfer(0, 1'b0, 32'hC, 32'h0);
        check("pop_after_empty", last_rd, 32'h77);

        // Wait-state instance: one push per transfer despite stretched ACCESS
        apb_xfer(1, 1'b1, 32'h0, 32'h1);
        apb_xfer(1, 1'b1, 32'h8, 32'hCAFE_0001);
        apb_xfer(1, 1'b0, 32'h4, 32'h0);
        check("status_wait_push", last_rd, 32'h0000_0100);
        apb_xfer(1, 1'b1, 32'h0, 32'h3);

        // Reset during the wait phase of a TXDATA write
        @(negedge PCLK);
        psel[1] = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h8;
        PWDATA  = 32'hDEAD_0001;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("midrst_pready", 32'(pready[1]), 32'h0);
        check("midrst_prdata", prdata[1], 32'h0);
        model_reset();
        @(negedge PCLK);
        psel[1] = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
        apb_xfer(1, 1'b0, 32'h4, 32'h0);
        check("status_after_midrst", last_rd, 32'h0000_0001);
        apb_xfer(1, 1'b1, 32'h0, 32'h5);
        apb_xfer(1, 1'b1, 32'h8, 32'h1234_5678);
        apb_xfer(1, 1'b0, 32'hC, 32'h0);
        check("pop_after_midrst", last_rd, 32'h1234_5678);

        // Randomized traffic across both instances
        for (int n = 0; n < 300; n++) begin
            d     = int'($urandom_range(0, 1));
            kind  = int'($urandom_range(0, 6));
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            case (kind)
                0: begin
                    addr  = 32'h0;
                    wdata = {29'h0, 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
                end
                1: addr = 32'h4;
                2, 3: begin
                    addr = 32'h8;
                    wr   = 1'b1;
                end
                4, 5: addr = 32'hC;
                default: begin
                    addr = $urandom;
                    if (addr[11:0] < 12'h010) addr[8] = 1'b1;
                end
            endcase
            apb_xfer(d, wr, addr, wdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_fifo_slave.md
Name: apb_fifo_slave

Overview:
APB responder (completer) that hangs off one PSELx output of the SoC APB master. It exposes a 4-register map in front of an internal synchronous word FIFO, so the CPU can push and pop data over the bus. PREADY is stretched by a programmable number of wait states to exercise the master's ACCESS-state stall path. A level interrupt flags a non-empty FIFO.

Parameters:
DEPTH, 8, FIFO depth in 32-bit words; power of two, range 2..128
WAIT_CYCLES, 0, number of extra ACCESS cycles before PREADY is asserted; range 0..15

Ports:
PCLK  in  1  single clock; all logic on its rising edge
PRESET  in  1  asynchronous, active-low reset (0 = reset)
PSEL  in  1  slave select from the master decoder
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  32  byte address; only [11:0] decoded
PWDATA  in  32  write data
PRDATA  out  32  read data, valid while PREADY=1 on a read
PREADY  out  1  transfer completion
irq  out  1  CTRL.IRQ_EN & ~empty

Behaviour:
- Register map (PADDR[11:0]):
  - 0x000 CTRL (RW): [0] EN, [1] FLUSH (write-1, self-clearing, reads 0), [2] IRQ_EN, other bits read 0.
  - 0x004 STATUS (RO): [0] empty, [1] full, [15:8] count (0..DEPTH), other bits 0.
  - 0x008 TXDATA (WO): push PWDATA; reads return 0.
  - 0x00C RXDATA (RO): pop and return the head word; writes ignored.
  - Any other offset is unmapped: reads return 0, writes ignored.
- Reset values: PREADY=0, PRDATA=0, irq=0, CTRL=0, FIFO empty (count 0), FSM in IDLE, wait counter 0.
- FSM states:
  - IDLE: PREADY=0. On PSEL & ~PENABLE, latch PADDR/PWRITE/PWDATA, load counter with WAIT_CYCLES, go to ACCESS.
  - ACCESS:
    - While counter != 0: decrement, PREADY=0.
    - When counter == 0: PREADY=1 combinationally for exactly one cycle and the side effect executes on that same clock edge; then go to IDLE.
    - If PSEL drops in ACCESS (protocol violation), abort to IDLE with no side effect.
- Latency: with WAIT_CYCLES=N, PREADY rises in the (N+1)th ACCESS cycle. With N=0, every transfer is 2 cycles (SETUP + ACCESS).
- Side effects occur exactly once per transfer, never during wait cycles.
- PRDATA equals the selected register value only while PREADY=1 & ~PWRITE; otherwise 0.
  - An RXDATA read returns the head word, and the pop happens on the PREADY edge.
- Push rules: a push occurs only if EN=1 and not full. A push when full, or with EN=0, is dropped and the FIFO is unchanged.
- Pop rules: a pop when empty returns 0 and leaves the pointers unchanged.
- FLUSH: a write with bit1=1 empties the FIFO on the PREADY edge. EN and IRQ_EN take the written bit0 and bit2 in that same write.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, so full is count == DEPTH.
- A new SETUP phase is not accepted until the FSM has returned to IDLE; back-to-back transfers from the master work naturally.
- Reset asserted mid-transfer: everything returns to reset values immediately (asynchronous). The in-flight transfer has no effect.

Optional Feature:
APB_SLVERR_EN
- When defined: adds an output port PSLVERR (1 bit), reset 0. PSLVERR is asserted together with PREADY for:
  - an unmapped offset,
  - a push while full or with EN=0,
  - a pop while empty,
  - a write to STATUS or RXDATA.
  Side-effect suppression is identical to the undefined case.
- When undefined: no PSLVERR port; errored accesses complete silently with the same data and state effects.

Decomposition:
- Package apb_fifo_slave_pkg:
  - register offset localparams (CTRL_OFS, STATUS_OFS, TXDATA_OFS, RXDATA_OFS),
  - CTRL bit-index constants,
  - FSM state enum (ST_IDLE, ST_ACCESS).
- Sub-module apb_sync_fifo:
  - parameters DEPTH and WIDTH=32,
  - ports push, pop, flush, wdata, rdata (head, combinational), empty, full, count.
  - Internally ignores push when full and pop when empty.

Test Plan:
- Reset: hold PRESET=0 → PREADY=0, PRDATA=0, irq=0. Then read STATUS → 0x0000_0001 (empty, count 0).
- Write CTRL=0x5, then push 0xA5A5_0001 and 0xA5A5_0002 → STATUS=0x0000_0200, irq=1. Read RXDATA twice → 0xA5A5_0001 then 0xA5A5_0002. STATUS returns to 0x1, irq=0.
- With DEPTH=8, EN=1: push 9 words 0x10..0x18 → STATUS=0x0000_0802 (full, count 8). The ninth push is dropped (PSLVERR=1 if APB_SLVERR_EN). The first pop returns 0x10.
- With WAIT_CYCLES=3: measure a write → PREADY rises 4 cycles after ACCESS entry. Only one push occurs; count increments by exactly 1.
- With 3 words queued, write CTRL=0x3 → STATUS=0x1, and a CTRL read returns 0x1. Pop on empty → PRDATA=0, with no pointer change.
- Assert PRESET low during the ACCESS wait of a TXDATA write with WAIT_CYCLES=3 → count stays 0 and PREADY=0. The next transfer completes normally.
